// File: rtl/sparc_ifu_thrfsm_pkg.sv
// Shared definitions for the multi-thread IFU thread FSM array: state
// encodings, per-thread event bundle and the legal-state check.
package sparc_ifu_thrfsm_pkg;

  localparam int unsigned THRFSM_W = 5;

  typedef enum logic [THRFSM_W-1:0] {
    THRFSM_IDLE     = 5'b00000,
    THRFSM_WAIT     = 5'b00001,
    THRFSM_HALT     = 5'b00010,
    THRFSM_RUN      = 5'b00101,
    THRFSM_SPEC_RUN = 5'b00111,
    THRFSM_SPEC_RDY = 5'b10011,
    THRFSM_RDY      = 5'b11001
  } thrfsm_state_e;

  // Per-thread event bundle driven by swl/fcl
  typedef struct packed {
    logic completion;
    logic schedule;
    logic spec_ld;
    logic ldhit;
    logic stall;
    logic int_activate;
    logic halt;
    logic start;
    logic nuke;
    logic thaw;
    logic rst;
  } thrfsm_evt_t;

  function automatic logic thrfsm_legal(input logic [THRFSM_W-1:0] s);
    case (s)
      THRFSM_IDLE, THRFSM_WAIT, THRFSM_HALT, THRFSM_RUN,
      THRFSM_SPEC_RUN, THRFSM_SPEC_RDY, THRFSM_RDY: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparc_ifu_thrfsm_cell.sv
// One thread's state machine: next-state logic, state register, debug load,
// illegal-state decode and the WAIT watchdog (enabled by THRFSM_WDOG_EN).
module sparc_ifu_thrfsm_cell
  import sparc_ifu_thrfsm_pkg::*;
#(
  parameter int unsigned WDOG_W = 10
) (
  input  logic                clk,
  input  logic                arst_l,
  input  thrfsm_evt_t         evt,
  input  logic                switch_out,
  input  logic                sw_cond,
  input  logic                dbg_ld,
  input  logic [THRFSM_W-1:0] dbg_data,
  input  logic [WDOG_W-1:0]   wdog_limit,
  output logic [THRFSM_W-1:0] state,
  output logic [THRFSM_W-1:0] nstate,
  output logic                ill,
  output logic                wdog_exp
);

  logic [THRFSM_W-1:0] state_q, state_d;

  // switch_out/sw_cond are only consulted in the running states
  always_comb begin
    state_d = state_q;
    case (state_q)
      THRFSM_IDLE: begin
        if (evt.rst | evt.thaw)  state_d = THRFSM_WAIT;
        else if (evt.start)      state_d = THRFSM_RDY;
      end
      THRFSM_HALT: begin
        if (evt.nuke)                        state_d = THRFSM_IDLE;
        else if (evt.rst | evt.thaw)         state_d = THRFSM_WAIT;
        else if (evt.int_activate | evt.start) state_d = THRFSM_RDY;
      end
      THRFSM_RDY: begin
        if (evt.stall)         state_d = THRFSM_WAIT;
        else if (evt.schedule) state_d = THRFSM_RUN;
      end
      THRFSM_RUN: begin
        if (evt.stall | sw_cond) state_d = THRFSM_WAIT;
        else if (switch_out)     state_d = THRFSM_RDY;
      end
      THRFSM_WAIT: begin
        if (evt.nuke)            state_d = THRFSM_IDLE;
        else if (evt.halt)       state_d = THRFSM_HALT;
        else if (evt.stall)      state_d = THRFSM_WAIT;
        else if (evt.spec_ld)    state_d = THRFSM_SPEC_RDY;
        else if (evt.completion) state_d = THRFSM_RDY;
      end
      THRFSM_SPEC_RDY: begin
        if (evt.stall)                        state_d = THRFSM_WAIT;
        else if (evt.schedule & ~evt.ldhit)   state_d = THRFSM_SPEC_RUN;
        else if (evt.schedule &  evt.ldhit)   state_d = THRFSM_RUN;
        else if (evt.ldhit)                   state_d = THRFSM_RDY;
      end
      THRFSM_SPEC_RUN: begin
        if (evt.stall | sw_cond)          state_d = THRFSM_WAIT;
        else if (evt.ldhit & switch_out)  state_d = THRFSM_RDY;
        else if (evt.ldhit)               state_d = THRFSM_RUN;
        else if (switch_out)              state_d = THRFSM_SPEC_RDY;
      end
      default: begin
        if (evt.rst)       state_d = THRFSM_WAIT;
        else if (evt.nuke) state_d = THRFSM_IDLE;
      end
    endcase
    if (dbg_ld) state_d = dbg_data;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) state_q <= THRFSM_IDLE;
    else         state_q <= state_d;
  end

  assign state  = state_q;
  assign nstate = state_d;
  assign ill    = ~thrfsm_legal(state_q);

`ifdef THRFSM_WDOG_EN
  logic [WDOG_W-1:0] wcnt_q, wcnt_d;
  logic              wexp_q, wexp_d;
  logic              wait_stay;

  assign wait_stay = (state_q == THRFSM_WAIT) && (state_d == THRFSM_WAIT);

  // Count cycles spent continuously in WAIT; flag is sticky until WAIT is left
  always_comb begin
    wcnt_d = '0;
    wexp_d = 1'b0;
    if (wait_stay) begin
      wexp_d = wexp_q | ((wdog_limit != '0) && (wcnt_q == wdog_limit));
      wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      wcnt_q <= '0;
      wexp_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wexp_q <= wexp_d;
    end
  end

  assign wdog_exp = wexp_q;
`else
  logic wdog_unused;
  assign wdog_unused = ^wdog_limit;
  assign wdog_exp    = 1'b0;
`endif

endmodule

// File: rtl/sparc_ifu_thrfsm_array.sv
// NUM_THR-wide IFU thread FSM array with debug overwrite, rdy/run summaries
// and multiple-runner detection. Optional WAIT watchdog: THRFSM_WDOG_EN.
module sparc_ifu_thrfsm_array
  import sparc_ifu_thrfsm_pkg::*;
#(
  parameter int unsigned NUM_THR = 4,
  parameter int unsigned TID_W   = 2,
  parameter int unsigned WDOG_W  = 10
) (
  input  logic                      clk,
  input  logic                      arst_l,
  input  logic [NUM_THR-1:0]        completion,
  input  logic [NUM_THR-1:0]        schedule,
  input  logic [NUM_THR-1:0]        spec_ld,
  input  logic [NUM_THR-1:0]        ldhit,
  input  logic [NUM_THR-1:0]        stall,
  input  logic [NUM_THR-1:0]        int_activate,
  input  logic [NUM_THR-1:0]        halt_thread,
  input  logic [NUM_THR-1:0]        start_thread,
  input  logic [NUM_THR-1:0]        nuke_thread,
  input  logic [NUM_THR-1:0]        thaw_thread,
  input  logic [NUM_THR-1:0]        rst_thread,
  input  logic                      switch_out,
  input  logic                      sw_cond,
  input  logic                      dbg_wr_en,
  input  logic [TID_W-1:0]          dbg_wr_thr,
  input  logic [4:0]                dbg_wr_data,
  input  logic [WDOG_W-1:0]         wdog_limit,
  output logic [5*NUM_THR-1:0]      thr_state,
  output logic [5*NUM_THR-1:0]      thr_nstate,
  output logic [NUM_THR-1:0]        thr_rdy,
  output logic [NUM_THR-1:0]        thr_run,
  output logic                      run_err,
  output logic [NUM_THR-1:0]        ill_state,
  output logic [NUM_THR-1:0]        wdog_exp
);

  for (genvar i = 0; i < NUM_THR; i++) begin : g_thr
    thrfsm_evt_t         evt;
    logic                dbg_ld;
    logic [THRFSM_W-1:0] st;

    assign evt = '{completion:   completion[i],
                   schedule:     schedule[i],
                   spec_ld:      spec_ld[i],
                   ldhit:        ldhit[i],
                   stall:        stall[i],
                   int_activate: int_activate[i],
                   halt:         halt_thread[i],
                   start:        start_thread[i],
                   nuke:         nuke_thread[i],
                   thaw:         thaw_thread[i],
                   rst:          rst_thread[i]};

    // Out-of-range thread indices never match, so such writes are dropped
    assign dbg_ld = dbg_wr_en && (dbg_wr_thr == TID_W'(i));

    sparc_ifu_thrfsm_cell #(.WDOG_W(WDOG_W)) u_cell (
      .clk        (clk),
      .arst_l     (arst_l),
      .evt        (evt),
      .switch_out (switch_out),
      .sw_cond    (sw_cond),
      .dbg_ld     (dbg_ld),
      .dbg_data   (dbg_wr_data),
      .wdog_limit (wdog_limit),
      .state      (st),
      .nstate     (thr_nstate[5*i +: 5]),
      .ill        (ill_state[i]),
      .wdog_exp   (wdog_exp[i])
    );

    assign thr_state[5*i +: 5] = st;
    assign thr_rdy[i] = (st == THRFSM_RDY) || (st == THRFSM_SPEC_RDY);
    assign thr_run[i] = (st == THRFSM_RUN) || (st == THRFSM_SPEC_RUN);
  end

  // More than one bit set <=> clearing the lowest set bit leaves something
  assign run_err = |(thr_run & (thr_run - NUM_THR'(1)));

endmodule

// File: tb/tb_sparc_ifu_thrfsm_array.sv
// Randomized and directed bench for sparc_ifu_thrfsm_array against a
// transition-table reference model; a 3-thread instance covers dropped writes.
module tb_sparc_ifu_thrfsm_array;

  localparam int NT   = 4;
  localparam int WMAX = 1023;

  localparam logic [4:0] S_IDLE = 5'b00000, S_WAIT = 5'b00001, S_HALT = 5'b00010,
                         S_RUN  = 5'b00101, S_SRUN = 5'b00111, S_SRDY = 5'b10011,
                         S_RDY  = 5'b11001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_l;
  logic [NT-1:0] completion, schedule, spec_ld, ldhit, stall, int_activate;
  logic [NT-1:0] halt_thread, start_thread, nuke_thread, thaw_thread, rst_thread;
  logic          switch_out, sw_cond, dbg_wr_en;
  logic [1:0]    dbg_wr_thr;
  logic [4:0]    dbg_wr_data;
  logic [9:0]    wdog_limit;

  logic [5*NT-1:0] thr_state, thr_nstate;
  logic [NT-1:0]   thr_rdy, thr_run, ill_state, wdog_exp;
  logic            run_err;

  logic [14:0] s3, n3;
  logic [2:0]  rdy3, run3, ill3, wd3;
  logic        re3;

  sparc_ifu_thrfsm_array #(.NUM_THR(4), .TID_W(2), .WDOG_W(10)) dut (
    .clk(clk), .arst_l(arst_l), .completion(completion), .schedule(schedule),
    .spec_ld(spec_ld), .ldhit(ldhit), .stall(stall), .int_activate(int_activate),
    .halt_thread(halt_thread), .start_thread(start_thread), .nuke_thread(nuke_thread),
    .thaw_thread(thaw_thread), .rst_thread(rst_thread), .switch_out(switch_out),
    .sw_cond(sw_cond), .dbg_wr_en(dbg_wr_en), .dbg_wr_thr(dbg_wr_thr),
    .dbg_wr_data(dbg_wr_data), .wdog_limit(wdog_limit), .thr_state(thr_state),
    .thr_nstate(thr_nstate), .thr_rdy(thr_rdy), .thr_run(thr_run), .run_err(run_err),
    .ill_state(ill_state), .wdog_exp(wdog_exp));

  sparc_ifu_thrfsm_array #(.NUM_THR(3), .TID_W(2), .WDOG_W(10)) dut3 (
    .clk(clk), .arst_l(arst_l), .completion(completion[2:0]), .schedule(schedule[2:0]),
    .spec_ld(spec_ld[2:0]), .ldhit(ldhit[2:0]), .stall(stall[2:0]),
    .int_activate(int_activate[2:0]), .halt_thread(halt_thread[2:0]),
    .start_thread(start_thread[2:0]), .nuke_thread(nuke_thread[2:0]),
    .thaw_thread(thaw_thread[2:0]), .rst_thread(rst_thread[2:0]), .switch_out(switch_out),
    .sw_cond(sw_cond), .dbg_wr_en(dbg_wr_en), .dbg_wr_thr(dbg_wr_thr),
    .dbg_wr_data(dbg_wr_data), .wdog_limit(wdog_limit), .thr_state(s3),
    .thr_nstate(n3), .thr_rdy(rdy3), .thr_run(run3), .run_err(re3),
    .ill_state(ill3), .wdog_exp(wd3));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model
  logic [4:0] m_st  [NT];
  int         m_cnt [NT];
  bit         m_exp [NT];

  function automatic bit is_legal(logic [4:0] s);
    return s inside {S_IDLE, S_WAIT, S_HALT, S_RUN, S_SRUN, S_SRDY, S_RDY};
  endfunction

  function automatic logic [4:0] rule(logic [4:0] s, int i);
    bit c = completion[i], sch = schedule[i], sl = spec_ld[i], lh = ldhit[i];
    bit stl = stall[i], ia = int_activate[i], h = halt_thread[i], st = start_thread[i];
    bit nk = nuke_thread[i], th = thaw_thread[i], r = rst_thread[i];
    bit so = switch_out, sc = sw_cond;
    if (s == S_IDLE) return (r | th) ? S_WAIT : st ? S_RDY : s;
    if (s == S_HALT) return nk ? S_IDLE : (r | th) ? S_WAIT : (ia | st) ? S_RDY : s;
    if (s == S_RDY)  return stl ? S_WAIT : sch ? S_RUN : s;
    if (s == S_RUN)  return (stl | sc) ? S_WAIT : so ? S_RDY : s;
    if (s == S_WAIT) return nk ? S_IDLE : h ? S_HALT : stl ? S_WAIT : sl ? S_SRDY : c ? S_RDY : s;
    if (s == S_SRDY) return stl ? S_WAIT : (sch & !lh) ? S_SRUN : (sch & lh) ? S_RUN : lh ? S_RDY : s;
    if (s == S_SRUN) return (stl | sc) ? S_WAIT : (lh & so) ? S_RDY : lh ? S_RUN : so ? S_SRDY : s;
    return r ? S_WAIT : nk ? S_IDLE : s;
  endfunction

  function automatic logic [4:0] m_next(int i);
    if (dbg_wr_en && int'(dbg_wr_thr) == i) return dbg_wr_data;
    return rule(m_st[i], i);
  endfunction

  function automatic logic [5*NT-1:0] exp_svec();
    logic [5*NT-1:0] v;
    for (int i = 0; i < NT; i++) v[5*i +: 5] = m_st[i];
    return v;
  endfunction

  function automatic logic [5*NT-1:0] exp_nvec();
    logic [5*NT-1:0] v;
    for (int i = 0; i < NT; i++) v[5*i +: 5] = m_next(i);
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_rdy();
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = (m_st[i] == S_RDY) || (m_st[i] == S_SRDY);
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_run();
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = (m_st[i] == S_RUN) || (m_st[i] == S_SRUN);
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_ill();
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = !is_legal(m_st[i]);
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_wd();
    logic [NT-1:0] v = '0;
`ifdef THRFSM_WDOG_EN
    for (int i = 0; i < NT; i++) v[i] = m_exp[i];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_st[i] = S_IDLE; m_cnt[i] = 0; m_exp[i] = 0;
    end
  endtask

  task automatic clr_in();
    completion = '0; schedule = '0; spec_ld = '0; ldhit = '0; stall = '0;
    int_activate = '0; halt_thread = '0; start_thread = '0; nuke_thread = '0;
    thaw_thread = '0; rst_thread = '0; switch_out = 0; sw_cond = 0;
    dbg_wr_en = 0; dbg_wr_thr = '0; dbg_wr_data = '0;
  endtask

  // Advance one clock with current inputs; returns at the following negedge
  task automatic tick();
    logic [4:0] nx [NT];
    for (int i = 0; i < NT; i++) nx[i] = m_next(i);
    @(posedge clk);
    for (int i = 0; i < NT; i++) begin
      if (m_st[i] == S_WAIT && nx[i] == S_WAIT) begin
        if (wdog_limit != 0 && m_cnt[i] == int'(wdog_limit)) m_exp[i] = 1;
        if (m_cnt[i] < WMAX) m_cnt[i]++;
      end else begin
        m_cnt[i] = 0; m_exp[i] = 0;
      end
      m_st[i] = nx[i];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_l = 0;
    clr_in();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_l = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (thr_state !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", thr_state); end
    n_chk++; if (thr_rdy !== '0 || thr_run !== '0 || run_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_vec rdy=%b run=%b err=%b exp all 0", thr_rdy, thr_run, run_err); end
    n_chk++; if (ill_state !== '0 || wdog_exp !== '0) begin
      n_fail++; $display("FAIL reset_flags ill=%b wd=%b exp 0", ill_state, wdog_exp); end
    n_chk++; if (s3 !== '0) begin n_fail++; $display("FAIL reset_state3 got=%h exp=0", s3); end
  endtask

  task automatic test_start();
    clr_in();
    start_thread = 4'b0001;
    #1;
    n_chk++; if (thr_nstate !== {S_IDLE, S_IDLE, S_IDLE, S_RDY}) begin
      n_fail++; $display("FAIL start_nstate got=%h exp=%h", thr_nstate, {S_IDLE, S_IDLE, S_IDLE, S_RDY}); end
    tick(); clr_in();
    n_chk++; if (thr_state !== {S_IDLE, S_IDLE, S_IDLE, S_RDY}) begin
      n_fail++; $display("FAIL start_state got=%h exp=%h", thr_state, {S_IDLE, S_IDLE, S_IDLE, S_RDY}); end
    n_chk++; if (thr_rdy !== 4'b0001) begin n_fail++; $display("FAIL start_rdy got=%b exp=0001", thr_rdy); end
  endtask

  task automatic test_run_switch();
    clr_in();
    schedule = 4'b0001; rst_thread = 4'b0010;
    tick(); clr_in();
    n_chk++; if (thr_state[4:0] !== S_RUN || thr_state[9:5] !== S_WAIT || thr_run !== 4'b0001) begin
      n_fail++; $display("FAIL sched_run st=%h run=%b exp t0=RUN t1=WAIT run=0001", thr_state, thr_run); end
    switch_out = 1;
    tick(); clr_in();
    n_chk++; if (thr_state[4:0] !== S_RDY || thr_state[9:5] !== S_WAIT) begin
      n_fail++; $display("FAIL switch_out st=%h exp t0=RDY t1=WAIT", thr_state); end
    n_chk++; if (thr_state !== exp_svec()) begin
      n_fail++; $display("FAIL switch_model got=%h exp=%h", thr_state, exp_svec()); end
  endtask

  task automatic test_spec();
    clr_in(); rst_thread = 4'b0100; tick();
    clr_in(); spec_ld = 4'b0100; tick(); clr_in();
    n_chk++; if (thr_state[14:10] !== S_SRDY || thr_rdy[2] !== 1'b1) begin
      n_fail++; $display("FAIL spec_rdy t2=%b rdy=%b exp 10011", thr_state[14:10], thr_rdy); end
    schedule = 4'b0100; tick(); clr_in();
    n_chk++; if (thr_state[14:10] !== S_SRUN || thr_run !== 4'b0100) begin
      n_fail++; $display("FAIL spec_run t2=%b run=%b exp 00111 0100", thr_state[14:10], thr_run); end
    ldhit = 4'b0100; switch_out = 1; tick(); clr_in();
    n_chk++; if (thr_state[14:10] !== S_RDY || thr_state[4:0] !== S_RDY) begin
      n_fail++; $display("FAIL spec_hit_sw st=%h exp t2=RDY t0=RDY", thr_state); end
  endtask

  task automatic test_dbg();
    clr_in(); dbg_wr_en = 1; dbg_wr_thr = 2'd3; dbg_wr_data = 5'b11111;
    #1;
    n_chk++; if (thr_nstate[19:15] !== 5'b11111) begin
      n_fail++; $display("FAIL dbg_nstate got=%b exp=11111", thr_nstate[19:15]); end
    tick(); clr_in();
    n_chk++; if (thr_state[19:15] !== 5'b11111 || ill_state !== 4'b1000) begin
      n_fail++; $display("FAIL dbg_ill st3=%b ill=%b exp 11111 1000", thr_state[19:15], ill_state); end
    n_chk++; if (s3 !== exp_svec()[14:0] || ill3 !== 3'b000) begin
      n_fail++; $display("FAIL dbg_drop3 got=%h ill=%b exp=%h ill=000", s3, ill3, exp_svec()[14:0]); end
    rst_thread = 4'b1000; tick(); clr_in();
    n_chk++; if (thr_state[19:15] !== S_WAIT || ill_state !== 4'b0000) begin
      n_fail++; $display("FAIL ill_rst st3=%b ill=%b exp 00001 0000", thr_state[19:15], ill_state); end
    dbg_wr_en = 1; dbg_wr_thr = 2'd3; dbg_wr_data = S_RUN; tick(); clr_in();
    n_chk++; if (thr_state[19:15] !== S_RUN || s3 !== exp_svec()[14:0] || run3 !== 3'b000) begin
      n_fail++; $display("FAIL dbg_oor st3=%b s3=%h run3=%b exp 00101 %h 000", thr_state[19:15], s3, run3, exp_svec()[14:0]); end
  endtask

  task automatic test_run_err();
    clr_in(); dbg_wr_en = 1; dbg_wr_thr = 2'd0; dbg_wr_data = S_RUN; tick();
    clr_in(); dbg_wr_en = 1; dbg_wr_thr = 2'd1; dbg_wr_data = S_RUN; tick(); clr_in();
    n_chk++; if (run_err !== 1'b1 || thr_run !== 4'b1011) begin
      n_fail++; $display("FAIL run_err err=%b run=%b exp 1 1011", run_err, thr_run); end
    n_chk++; if (re3 !== 1'b1 || run3 !== 3'b011) begin
      n_fail++; $display("FAIL run_err3 err=%b run=%b exp 1 011", re3, run3); end
    @(posedge clk); #3;
    arst_l = 0;
    #1;
    n_chk++; if (thr_state !== '0 || run_err !== 1'b0 || thr_run !== '0 || s3 !== '0) begin
      n_fail++; $display("FAIL async_rst st=%h err=%b run=%b s3=%h exp 0", thr_state, run_err, thr_run, s3); end
    model_reset();
    @(negedge clk);
    arst_l = 1;
  endtask

  task automatic test_wdog();
    clr_in(); wdog_limit = 10'd5;
    rst_thread = 4'b0001; tick(); clr_in();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++;
`ifdef THRFSM_WDOG_EN
      if (wdog_exp[0] !== (k >= 6)) begin
        n_fail++; $display("FAIL wdog_k%0d got=%b exp=%b", k, wdog_exp[0], k >= 6); end
`else
      if (wdog_exp !== 4'b0000) begin
        n_fail++; $display("FAIL wdog_off_k%0d got=%b exp=0000", k, wdog_exp); end
`endif
    end
    completion = 4'b0001; tick(); clr_in();
    n_chk++; if (thr_state[4:0] !== S_RDY || wdog_exp[0] !== 1'b0) begin
      n_fail++; $display("FAIL wdog_clear st0=%b wd=%b exp 11001 0", thr_state[4:0], wdog_exp[0]); end
  endtask

  function automatic logic [4:0] pick_legal(int k);
    case (k)
      0: return S_IDLE; 1: return S_WAIT; 2: return S_HALT; 3: return S_RUN;
      4: return S_SRUN; 5: return S_SRDY; default: return S_RDY;
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wdog_limit   = 10'((cyc / 150) % 4);
      completion   = 4'($urandom & $urandom & $urandom);
      schedule     = 4'($urandom & $urandom);
      spec_ld      = 4'($urandom & $urandom & $urandom);
      ldhit        = 4'($urandom & $urandom);
      stall        = 4'($urandom & $urandom & $urandom);
      int_activate = 4'($urandom & $urandom);
      halt_thread  = 4'($urandom & $urandom & $urandom & $urandom);
      start_thread = 4'($urandom & $urandom);
      nuke_thread  = 4'($urandom & $urandom & $urandom & $urandom);
      thaw_thread  = 4'($urandom & $urandom & $urandom);
      rst_thread   = 4'($urandom & $urandom & $urandom);
      switch_out   = ($urandom_range(0, 3) == 0);
      sw_cond      = ($urandom_range(0, 5) == 0);
      dbg_wr_en    = ($urandom_range(0, 7) == 0);
      dbg_wr_thr   = 2'($urandom);
      dbg_wr_data  = ($urandom_range(0, 1) == 0) ? pick_legal($urandom_range(0, 6)) : 5'($urandom);
      #1;
      n_chk++; if (thr_nstate !== exp_nvec()) begin
        n_fail++; $display("FAIL rnd_nstate c%0d got=%h exp=%h", cyc, thr_nstate, exp_nvec()); end
      tick();
      n_chk++; if (thr_state !== exp_svec()) begin
        n_fail++; $display("FAIL rnd_state c%0d got=%h exp=%h", cyc, thr_state, exp_svec()); end
      n_chk++; if (thr_rdy !== exp_rdy() || thr_run !== exp_run()) begin
        n_fail++; $display("FAIL rnd_rdyrun c%0d rdy=%b run=%b exp %b %b", cyc, thr_rdy, thr_run, exp_rdy(), exp_run()); end
      n_chk++; if (run_err !== ($countones(exp_run()) > 1)) begin
        n_fail++; $display("FAIL rnd_runerr c%0d got=%b", cyc, run_err); end
      n_chk++; if (ill_state !== exp_ill() || wdog_exp !== exp_wd()) begin
        n_fail++; $display("FAIL rnd_flags c%0d ill=%b wd=%b exp %b %b", cyc, ill_state, wdog_exp, exp_ill(), exp_wd()); end
      n_chk++; if (s3 !== exp_svec()[14:0] || ill3 !== exp_ill()[2:0] || wd3 !== exp_wd()[2:0]) begin
        n_fail++; $display("FAIL rnd_thr3 c%0d got=%h exp=%h", cyc, s3, exp_svec()[14:0]); end
    end
  endtask

  initial begin
    arst_l = 1;
    wdog_limit = '0;
    clr_in();
    model_reset();
    test_reset();
    test_start();
    test_run_switch();
    test_spec();
    test_dbg();
    test_run_err();
    test_wdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_thrfsm_array.md
Name: sparc_ifu_thrfsm_array

Overview:
Parametrised multi-thread successor to the single-thread IFU thread FSM. It holds NUM_THR independent thread state machines with identical state encoding, and adds the following:
- a thread-indexed debug/JTAG state overwrite;
- ready/run summary vectors;
- multiple-runner and illegal-state detection;
- an optional per-thread WAIT watchdog.

It sits between the IFU switch logic (swl/fcl), which drives the events, and the thread scheduler, which consumes the rdy/run vectors.

Parameters:
NUM_THR, 4, number of hardware threads (1..8)
TID_W, 2, width of the debug thread index (clog2(NUM_THR), minimum 1)
WDOG_W, 10, watchdog counter width (used only with the optional feature)

Ports:
clk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
completion, schedule, spec_ld, ldhit, stall, int_activate, halt_thread, start_thread, nuke_thread, thaw_thread, rst_thread  in  NUM_THR each  per-thread events, bit i = thread i
switch_out  in  1  the currently running thread is switched out
sw_cond  in  1  the running thread waits for completion
dbg_wr_en  in  1  debug state overwrite strobe
dbg_wr_thr  in  TID_W  thread selected for overwrite
dbg_wr_data  in  5  state value to write
wdog_limit  in  WDOG_W  WAIT timeout threshold (optional feature only)
thr_state  out  5*NUM_THR  registered states, thread i in bits [5i+4:5i]
thr_nstate  out  5*NUM_THR  combinational next states
thr_rdy  out  NUM_THR  state is RDY or SPEC_RDY
thr_run  out  NUM_THR  state is RUN or SPEC_RUN
run_err  out  1  more than one bit of thr_run is set
ill_state  out  NUM_THR  registered state is not a legal encoding
wdog_exp  out  NUM_THR  watchdog expired (optional feature only)

Behaviour:
- State encodings: IDLE 00000, WAIT 00001, HALT 00010, RUN 00101, SPEC_RUN 00111, SPEC_RDY 10011, RDY 11001.
- Reset: arst_l low asynchronously forces every thread to IDLE. All derived outputs are then 0, and wdog counters/flags clear.
- Latency: state updates on the clk rising edge. thr_nstate is same-cycle combinational. thr_rdy, thr_run, run_err and ill_state decode the registered state.
- Transitions per thread i (priority top-down within each state):
  - IDLE: rst|thaw -> WAIT; start -> RDY; else hold. All other events are ignored.
  - HALT: nuke -> IDLE; rst|thaw -> WAIT; int_activate|start -> RDY; else hold.
  - RDY: stall -> WAIT; schedule -> RUN; else hold.
  - RUN: stall|sw_cond -> WAIT; switch_out -> RDY; else hold.
  - WAIT: nuke -> IDLE; halt -> HALT; stall -> WAIT; spec_ld -> SPEC_RDY; completion -> RDY; else hold.
  - SPEC_RDY: stall -> WAIT; schedule&~ldhit -> SPEC_RUN; schedule&ldhit -> RUN; ldhit -> RDY; else hold.
  - SPEC_RUN: stall|sw_cond -> WAIT; ldhit&switch_out -> RDY; ldhit -> RUN; switch_out -> SPEC_RDY; else hold.
  - Illegal state: rst -> WAIT; nuke -> IDLE; else hold. ill_state[i] is asserted while the illegal value is held.
- Common inputs: switch_out and sw_cond affect only threads whose registered state is RUN or SPEC_RUN. They are ignored for all other threads.
- Debug write: when dbg_wr_en=1 and dbg_wr_thr<NUM_THR, the selected thread loads dbg_wr_data.
  - This overrides next_state, and illegal values are accepted.
  - All other threads advance normally in the same cycle.
  - dbg_wr_thr>=NUM_THR: the write is dropped and all threads advance normally.
- run_err: combinational flag, set when popcount(thr_run)>1. It does not alter any state.
- Simultaneous events: resolved purely by the per-state priority order above. Reset overrides everything, including a debug write.

Optional Feature:
Macro: THRFSM_WDOG_EN.
- Defined:
  - Each thread has a WDOG_W-bit counter. It clears on any cycle where the thread's next state is not WAIT, or where the thread is entering WAIT from another state.
  - While the thread stays in WAIT, the counter increments and saturates at all-ones.
  - wdog_exp[i] is set registered on the cycle after the counter equals wdog_limit, with wdog_limit≠0.
  - The flag stays sticky until the thread leaves WAIT or reset.
  - wdog_limit=0 disables the watchdog.
- Not defined: no counters are built, wdog_exp is tied to 0, and wdog_limit is unused.

Decomposition:
- Shared package/header: the seven THRFSM_* state encodings and a legal-state check function/macro.
- Sub-module sparc_ifu_thrfsm_cell holds one thread's next-state logic, state register, debug load, illegal decode and optional watchdog. The top generates NUM_THR instances and performs the rdy/run/run_err reduction.

Test Plan:
- Reset then start_thread=0001 -> thread0 is RDY next cycle; thr_rdy=0001, other threads stay IDLE.
- Thread0 RDY, schedule[0]=1 -> RUN. Then switch_out=1 -> RDY. Thread1 in WAIT with switch_out=1 -> stays WAIT.
- Thread2 WAIT, spec_ld, then schedule with ldhit=0 -> SPEC_RUN. Next ldhit=1, switch_out=1 -> RDY.
- dbg_wr_en, dbg_wr_thr=3, dbg_wr_data=11111 -> thread3=11111 and ill_state[3]=1; rst_thread[3] -> WAIT. dbg_wr_thr out of range with NUM_THR=3 -> no state change.
- Debug-write RUN into threads 0 and 1 -> run_err=1. Assert arst_l low mid-cycle -> all threads IDLE immediately, run_err=0.
- THRFSM_WDOG_EN, wdog_limit=5, thread0 held in WAIT -> wdog_exp[0]=1 six cycles after WAIT entry. completion -> RDY and the flag clears.
